// File: rtl/gr_read_unit_pkg.sv
// Shared sizing constants for the general-register read unit.
// Pairs with the `WORD_LENGTH macro used elsewhere in the CPU.
package gr_read_unit_pkg;

    localparam int unsigned DEF_WORD_LENGTH = 32;
    localparam int unsigned DEF_NUM_REGS    = 16;
    localparam int unsigned DEF_REG_ADDR_W  = 4;
    localparam int unsigned R0_IDX          = 0;

endpackage

// File: rtl/gr_read_unit_scoreboard.sv
// Per-register busy scoreboard with set-over-clear priority, R0 masking and hazard flags.
// Optional macro GR_BYPASS_EN: a write-back in the current cycle resolves the hazard.
module gr_read_unit_scoreboard
    import gr_read_unit_pkg::*;
#(
    parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_set,
    input  logic [REG_ADDR_W-1:0] iss_dest,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [REG_ADDR_W-1:0] src_a,
    input  logic [REG_ADDR_W-1:0] src_b,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic                  hazard_a_c,
    output logic                  hazard_b_c
);

    logic [NUM_REGS-1:0] busy_d;

    // Issue marks after write-back clears so a same-cycle collision stays busy.
    always_comb begin
        busy_d = busy_vec;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (iss_set) begin
            busy_d[iss_dest] = 1'b1;
        end
        busy_d[R0_IDX] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_d;
        end
    end

    always_comb begin
`ifdef GR_BYPASS_EN
        hazard_a_c = busy_vec[src_a] && !(wb_en && (wb_addr == src_a));
        hazard_b_c = busy_vec[src_b] && !(wb_en && (wb_addr == src_b));
`else
        hazard_a_c = busy_vec[src_a];
        hazard_b_c = busy_vec[src_b];
`endif
    end

endmodule

// File: rtl/gr_read_unit.sv
// General-register file with one write-back port and a registered dual-operand read port.
// Optional macro GR_BYPASS_EN: forward same-cycle write-back data to the operand register.
module gr_read_unit
    import gr_read_unit_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = DEF_WORD_LENGTH,
    parameter int unsigned NUM_REGS    = DEF_NUM_REGS,
    parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [REG_ADDR_W-1:0]  rd_a_addr,
    input  logic [REG_ADDR_W-1:0]  rd_b_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] out_a,
    output logic [WORD_LENGTH-1:0] out_b,
    input  logic                   iss_set,
    input  logic [REG_ADDR_W-1:0]  iss_dest,
    input  logic                   wb_en,
    input  logic [REG_ADDR_W-1:0]  wb_addr,
    input  logic [WORD_LENGTH-1:0] wb_data,
    output logic [NUM_REGS-1:0]    busy_vec
);

    localparam logic [REG_ADDR_W-1:0] R0_ADDR = REG_ADDR_W'(R0_IDX);

    logic [WORD_LENGTH-1:0] regs_q [NUM_REGS];
    logic                   hazard_a_c;
    logic                   hazard_b_c;
    logic                   accept_c;
    logic [WORD_LENGTH-1:0] op_a_c;
    logic [WORD_LENGTH-1:0] op_b_c;
    logic                   out_valid_d;
    logic [WORD_LENGTH-1:0] out_a_d;
    logic [WORD_LENGTH-1:0] out_b_d;

    gr_read_unit_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .iss_set    (iss_set),
        .iss_dest   (iss_dest),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .src_a      (rd_a_addr),
        .src_b      (rd_b_addr),
        .busy_vec   (busy_vec),
        .hazard_a_c (hazard_a_c),
        .hazard_b_c (hazard_b_c)
    );

    // Register array; R0 is never written so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != R0_ADDR)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Operand selection; R0 forced to zero after any forwarding.
    always_comb begin
        op_a_c = regs_q[rd_a_addr];
        op_b_c = regs_q[rd_b_addr];
`ifdef GR_BYPASS_EN
        if (wb_en && (wb_addr == rd_a_addr)) begin
            op_a_c = wb_data;
        end
        if (wb_en && (wb_addr == rd_b_addr)) begin
            op_b_c = wb_data;
        end
`endif
        if (rd_a_addr == R0_ADDR) begin
            op_a_c = '0;
        end
        if (rd_b_addr == R0_ADDR) begin
            op_b_c = '0;
        end
    end

    assign rd_ready = (!out_valid || out_ready) && !hazard_a_c && !hazard_b_c;
    assign accept_c = rd_valid && rd_ready;

    // Output slot: load on accept, hold under backpressure, empty when drained.
    always_comb begin
        out_valid_d = out_valid;
        out_a_d     = out_a;
        out_b_d     = out_b;
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_a_d     = op_a_c;
            out_b_d     = op_b_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
        end else begin
            out_valid <= out_valid_d;
            out_a     <= out_a_d;
            out_b     <= out_b_d;
        end
    end

endmodule

// File: tb/tb_gr_read_unit.sv
// Scoreboard bench for gr_read_unit; expectations follow GR_BYPASS_EN when it is defined.
module tb_gr_read_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_valid;
    logic        rd_ready;
    logic [3:0]  rd_a_addr;
    logic [3:0]  rd_b_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        iss_set;
    logic [3:0]  iss_dest;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [15:0] busy_vec;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    gr_read_unit dut (
        .clk       (clk),
        .rst       (rst),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_a_addr (rd_a_addr),
        .rd_b_addr (rd_b_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .iss_set   (iss_set),
        .iss_dest  (iss_dest),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy_vec  (busy_vec)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one read, wait (bounded) for acceptance, then check 1-cycle latency.
    task automatic issue_read(input logic [3:0] a, input logic [3:0] b,
                              input logic [31:0] ea, input logic [31:0] eb);
        bit done = 0;
        rd_valid  = 1'b1;
        rd_a_addr = a;
        rd_b_addr = b;
        exp_q.push_back({ea, eb});
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            if (rd_ready) done = 1;
            @(posedge clk);
            #1;
        end
        rd_valid = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout: rd_ready stayed %b expected 1", rd_ready);
        end else begin
            check("latency_valid", 32'(out_valid), 32'd1);
        end
    endtask

    // Read stalled on a busy register, released by a write-back to wa.
    task automatic wb_release_read(input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] wa, input logic [31:0] wdata,
                                   input logic [31:0] ea, input logic [31:0] eb);
        rd_valid  = 1'b1;
        rd_a_addr = a;
        rd_b_addr = b;
        #1;
        check("stall_rdy", 32'(rd_ready), 32'd0);
        tick();
        check("stall_rdy_hold", 32'(rd_ready), 32'd0);
        exp_q.push_back({ea, eb});
        wb_en   = 1'b1;
        wb_addr = wa;
        wb_data = wdata;
        #1;
`ifdef GR_BYPASS_EN
        check("bypass_rdy", 32'(rd_ready), 32'd1);
        tick();
        wb_en = 1'b0;
`else
        check("wb_cycle_rdy", 32'(rd_ready), 32'd0);
        tick();
        wb_en = 1'b0;
        #1;
        check("post_wb_rdy", 32'(rd_ready), 32'd1);
        tick();
`endif
        rd_valid = 1'b0;
        check("release_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    // Monitor: pop on each handshake, and check operands hold under backpressure.
    logic        held_v = 1'b0;
    logic [63:0] held;
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %h_%h with empty queue", out_a, out_b);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("out_a", out_a, e[63:32]);
                check("out_b", out_b, e[31:0]);
            end
        end
        if (out_valid && !out_ready) begin
            if (held_v) begin
                check("hold_a", out_a, held[63:32]);
                check("hold_b", out_b, held[31:0]);
            end
            held_v = 1'b1;
            held   = {out_a, out_b};
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        rst = 1'b1; rd_valid = 1'b0; rd_a_addr = '0; rd_b_addr = '0;
        out_ready = 1'b1; iss_set = 1'b0; iss_dest = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy_vec), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_rdy", 32'(rd_ready), 32'd1);
        issue_read(4'd3, 4'd7, 32'h0, 32'h0);
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Write then read, plus R0 immunity
        write_reg(4'd5, 32'h12345678);
        issue_read(4'd5, 4'd0, 32'h12345678, 32'h0);
        write_reg(4'd0, 32'hFFFFFFFF);
        iss_set = 1'b1; iss_dest = 4'd0;
        tick();
        iss_set = 1'b0;
        check("r0_busy", 32'(busy_vec), 32'd0);
        issue_read(4'd0, 4'd0, 32'h0, 32'h0);

        // Scoreboard stall released by write-back
        iss_set = 1'b1; iss_dest = 4'd4;
        tick();
        iss_set = 1'b0;
        check("busy_r4", 32'(busy_vec), 32'h0010);
        wb_release_read(4'd4, 4'd0, 4'd4, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0);
        check("busy_clr", 32'(busy_vec), 32'd0);

        // Backpressure: hold for 3 cycles, then next pair accepted on release
        tick();
        out_ready = 1'b0;
        issue_read(4'd5, 4'd4, 32'h12345678, 32'hCAFEF00D);
        rd_valid = 1'b1; rd_a_addr = 4'd4; rd_b_addr = 4'd5;
        exp_q.push_back({32'hCAFEF00D, 32'h12345678});
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rdy", 32'(rd_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(rd_ready), 32'd1);
        tick();
        rd_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        tick();

        // Set/clear collision: set wins, data still written
        iss_set = 1'b1; iss_dest = 4'd9;
        wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'h1;
        tick();
        iss_set = 1'b0; wb_en = 1'b0;
        check("collide_busy", 32'(busy_vec), 32'h0200);
        wb_release_read(4'd9, 4'd9, 4'd9, 32'h55, 32'h55, 32'h55);
        tick();

        // Reset mid-operation discards held pair and busy bits
        write_reg(4'd2, 32'h77);
        iss_set = 1'b1; iss_dest = 4'd2;
        tick();
        iss_set = 1'b0;
        out_ready = 1'b0;
        rd_valid = 1'b1; rd_a_addr = 4'd5; rd_b_addr = 4'd5;
        tick();
        rd_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_busy", 32'(busy_vec), 32'h0004);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy_vec), 32'd0);
        out_ready = 1'b1;
        issue_read(4'd2, 4'd5, 32'h0, 32'h0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
